mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-input 32-bit select mux.
- Shares one downstream 32-bit channel among four requesters, with a valid/ready handshake on the output.
- Drives the 2-bit mux select from a registered grant.
- Caps consecutive beats per grant at MAX_BURST so no requester starves the others.

Parameters:
- WIDTH, 32, data width of each input and of out_data.
- MAX_BURST, 4, maximum beats transferred per grant before forced rotation; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  4  per-requester request; req[i] high means in_i holds a valid beat.
- in_0, in_1, in_2, in_3  input  WIDTH  requester data.
- out_ready  input  1  downstream accepts a beat this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  WIDTH  selected input data.
- select  output  2  registered mux select; equals the index of the granted requester.
- grant  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  combinational per-requester beat accept; ack = grant & {4{out_valid & out_ready}}.
- busy  output  1  high while in the GRANT state.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, grant=0000, select=00, ptr=0, beat_cnt=0. Outputs then read out_valid=0, busy=0, ack=0000; out_data=in_0.
- Reset applied mid-burst takes effect at that edge, discarding the burst. A beat accepted in that same cycle is still acked combinationally.
- Datapath is combinational:
  - out_data = in_[select], always driven, including when idle.
  - out_valid = busy & req[select].
  - transfer = out_valid & out_ready.
- Arbitration function pick(r, p): first index i in the order p, p+1, ... p+3 (mod 4) with r[i]=1.
- IDLE:
  - If req != 0: next state GRANT, owner = pick(req, ptr), grant = onehot(owner), select = owner, beat_cnt = 0.
  - Otherwise remain in IDLE.
  - Latency: req rising before edge N gives grant/out_valid visible after edge N (one cycle).
- GRANT: owner = select. A release occurs when either condition holds:
  - (a) req[owner]=0 (requester withdrew; no transfer is possible this cycle), or
  - (b) transfer and beat_cnt == MAX_BURST-1.
- On a transfer without release: beat_cnt += 1.
- On a release:
  - ptr = (owner+1) mod 4.
  - Re-arbitrate in the same cycle using r = req with bit owner cleared under (a); under (b) r = req unchanged.
  - If r != 0: stay in GRANT with the new owner = pick(r, (owner+1) mod 4) and beat_cnt = 0. There is no bubble cycle.
  - Under (b), the old owner wins again only when it is the sole requester.
  - If r = 0: go to IDLE, grant=0000, select held at last owner.
- Downstream stall (out_valid=1, out_ready=0): grant, select, beat_cnt and out_data held stable. Requesters must hold in_i and req[i] until ack[i].
- Requesters not granted see ack=0 and must hold their data.
- beat_cnt is 4 bits wide and never exceeds MAX_BURST-1.
- MAX_BURST=1: rotation occurs after every transfer.
- Simultaneous requests on all four inputs: service order ptr, ptr+1, ..., strictly round-robin.
- No combinational path from out_ready to grant or select; only ack and the next-state logic depend on it.

Test Plan:
- Reset, then req=0000 for 5 cycles -> grant=0000, select=00, out_valid=0, busy=0 throughout.
- req=0100, in_2=32'hCAFE0002, out_ready=1 -> next cycle grant=0100, select=10, out_valid=1, out_data=32'hCAFE0002. After 4 beats (MAX_BURST=4) the block re-grants 2 with no bubble, since it is the sole requester.
- req=1111 held, out_ready=1, inputs in_i=32'h0000000i -> grant sequence 0001×4 beats, 0010×4, 0100×4, 1000×4, then 0001 again. ack matches grant each cycle.
- Owner 1 in GRANT, out_ready=0 for 3 cycles -> out_data, select=01 and beat_cnt unchanged, ack=0000. Raise out_ready -> ack=0010 on that cycle.
- Owner 0 drops req[0] after 2 beats while req[3]=1 -> grant switches to 1000 on the next edge, beat_cnt restarts at 0, ptr=1.
- rst_n=0 for one edge mid-burst (owner 2, beat_cnt=2) -> after that edge grant=0000, select=00, busy=0. With req=0100 still high, grant=0100 re-asserts one cycle after rst_n returns high.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
`timescale 1ns/1ps
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer for a 4-input select mux. It shares one
//   downstream channel among four requesters using a valid/ready handshake.
//   The grant is held for at most MAX_BURST accepted beats. After that the
//   grant rotates, so one requester cannot starve the others.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   per-requester request; req[i] means in_i holds a valid beat
//   in_0..in_3 requester data
//   out_ready  downstream accepts a beat this cycle
//   out_valid  out_data holds a valid beat
//   out_data   selected input data (always driven, in_0 after reset)
//   select     registered mux select (index of the granted requester)
//   grant      registered one-hot grant; zero when idle
//   ack        per-requester beat accept (grant qualified by transfer)
//   busy       high while a requester holds the grant
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4    // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       select,
  output logic [3:0]       grant,
  output logic [3:0]       ack,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state, state_n;
  logic [3:0] grant_n;
  logic [1:0] select_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] beat_cnt, beat_cnt_n;

  logic       transfer;
  logic       withdraw;
  logic       burst_end;
  logic       rel;
  logic [3:0] rearb_req;
  logic [1:0] owner_n;

  // First index with a set request, searching p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = p + k[1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      select   <= select_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Next-state logic. A release re-arbitrates in the same cycle, so a
  // waiting requester gets the channel without an idle bubble. On a
  // withdrawal, the old owner's bit is masked out of the new arbitration.
  // On a burst end it is not masked, so the old owner wins again only when
  // it is the sole requester.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    select_n   = select;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    withdraw   = 1'b0;
    burst_end  = 1'b0;
    rel        = 1'b0;
    rearb_req  = '0;
    owner_n    = select;

    case (state)
      IDLE: begin
        if (req != '0) begin
          owner_n    = pick(req, ptr);
          state_n    = GRANT;
          grant_n    = onehot(owner_n);
          select_n   = owner_n;
          beat_cnt_n = '0;
        end
      end

      GRANT: begin
        withdraw  = ~req[select];
        burst_end = transfer && (beat_cnt == LAST_BEAT);
        rel       = withdraw || burst_end;
        if (rel) begin
          ptr_n      = select + 2'd1;
          beat_cnt_n = '0;
          rearb_req  = withdraw ? (req & ~onehot(select)) : req;
          if (rearb_req != '0) begin
            owner_n  = pick(rearb_req, select + 2'd1);
            grant_n  = onehot(owner_n);
            select_n = owner_n;
          end else begin
            // select keeps the last owner, so out_data stays put while idle
            state_n = IDLE;
            grant_n = '0;
          end
        end else if (transfer) begin
          beat_cnt_n = beat_cnt + 4'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Outputs: the datapath and handshake are combinational off registered state
  always_comb begin
    busy      = (state == GRANT);
    out_valid = busy && req[select];
    transfer  = out_valid && out_ready;
    ack       = grant & {4{transfer}};
    case (select)
      2'd0:    out_data = in_0;
      2'd1:    out_data = in_1;
      2'd2:    out_data = in_2;
      default: out_data = in_3;
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] in_v [4];
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  select;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;

  mux4_rr_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_0      (in_v[0]),
    .in_1      (in_v[1]),
    .in_2      (in_v[2]),
    .in_3      (in_v[3]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .select    (select),
    .grant     (grant),
    .ack       (ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [31:0] d;
  } beat_t;

  beat_t exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] d, input int n);
    beat_t b;
    b.g = g;
    b.d = d;
    repeat (n) exp_q.push_back(b);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(grant), 32'h0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_grant", 32'(grant), 32'(e.g));
        chk("beat_ack",   32'(ack),   32'(e.g));
        chk("beat_data",  out_data,   e.d);
      end
    end else if (out_valid) begin
      chk("stall_ack", 32'(ack), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    in_v[0]   = 32'h11110000;
    in_v[1]   = 32'h22220001;
    in_v[2]   = 32'h33330002;
    in_v[3]   = 32'h44440003;

    // Reset state, then idle with no requests
    step(2);
    chk("rst_grant",  32'(grant),     32'h0);
    chk("rst_select", 32'(select),    32'h0);
    chk("rst_valid",  32'(out_valid), 32'h0);
    chk("rst_busy",   32'(busy),      32'h0);
    chk("rst_ack",    32'(ack),       32'h0);
    chk("rst_data",   out_data,       32'h11110000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("idle_grant",  32'(grant),     32'h0);
      chk("idle_select", 32'(select),    32'h0);
      chk("idle_valid",  32'(out_valid), 32'h0);
      chk("idle_busy",   32'(busy),      32'h0);
    end

    // Sole requester 2: two full bursts, re-granted without a bubble
    in_v[2]   = 32'hCAFE0002;
    req       = 4'b0100;
    out_ready = 1'b1;
    push(4'b0100, 32'hCAFE0002, 8);
    step(1);
    chk("solo_grant",  32'(grant),     32'h4);
    chk("solo_select", 32'(select),    32'h2);
    chk("solo_valid",  32'(out_valid), 32'h1);
    chk("solo_data",   out_data,       32'hCAFE0002);
    step(8);
    req = 4'b0000;
    step(2);
    chk("solo_done_busy",  32'(busy),  32'h0);
    chk("solo_done_grant", 32'(grant), 32'h0);

    // All four requesting from ptr=0: strict rotation in bursts of four
    rst_n = 1'b0;
    step(1);
    rst_n   = 1'b1;
    in_v[0] = 32'h00000000;
    in_v[1] = 32'h00000001;
    in_v[2] = 32'h00000002;
    in_v[3] = 32'h00000003;
    req     = 4'b1111;
    push(4'b0001, 32'h00000000, 4);
    push(4'b0010, 32'h00000001, 4);
    push(4'b0100, 32'h00000002, 4);
    push(4'b1000, 32'h00000003, 4);
    push(4'b0001, 32'h00000000, 4);
    step(1);
    chk("rr_first_grant", 32'(grant), 32'h1);
    step(20);
    req = 4'b0000;
    step(2);

    // Owner 1 stalled by the downstream for three cycles
    in_v[1]   = 32'hAAAA0001;
    req       = 4'b0010;
    out_ready = 1'b0;
    step(1);
    chk("stall_grant", 32'(grant), 32'h2);
    for (int i = 0; i < 3; i++) begin
      chk("stall_select", 32'(select),    32'h1);
      chk("stall_valid",  32'(out_valid), 32'h1);
      chk("stall_data",   out_data,       32'hAAAA0001);
      chk("stall_ack0",   32'(ack),       32'h0);
      step(1);
    end
    push(4'b0010, 32'hAAAA0001, 1);
    out_ready = 1'b1;
    #1;
    chk("stall_release_ack", 32'(ack), 32'h2);
    step(1);
    out_ready = 1'b0;
    req       = 4'b0000;
    step(2);

    // Owner 0 withdraws after two beats; requester 3 takes over at once
    rst_n = 1'b0;
    step(1);
    rst_n     = 1'b1;
    in_v[0]   = 32'hD0D00000;
    in_v[3]   = 32'hD0D00003;
    req       = 4'b1001;
    out_ready = 1'b1;
    push(4'b0001, 32'hD0D00000, 2);
    step(1);
    chk("wd_grant0", 32'(grant), 32'h1);
    step(2);
    req = 4'b1000;
    step(1);
    chk("wd_grant3",  32'(grant),  32'h8);
    chk("wd_select3", 32'(select), 32'h3);
    // a fresh four-beat burst for 3, then rotation to 1
    in_v[1] = 32'hD0D00001;
    req     = 4'b1010;
    push(4'b1000, 32'hD0D00003, 4);
    push(4'b0010, 32'hD0D00001, 1);
    step(5);
    req = 4'b0000;
    step(2);

    // Reset mid-burst: owner 2 at beat_cnt=2, beat in the reset cycle still acked
    in_v[2]   = 32'hBEEF0002;
    req       = 4'b0100;
    out_ready = 1'b1;
    push(4'b0100, 32'hBEEF0002, 3);
    step(1);
    chk("mid_grant", 32'(grant), 32'h4);
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_grant",  32'(grant),     32'h0);
    chk("mid_rst_select", 32'(select),    32'h0);
    chk("mid_rst_busy",   32'(busy),      32'h0);
    chk("mid_rst_valid",  32'(out_valid), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step(1);
    chk("post_rst_grant",  32'(grant),     32'h4);
    chk("post_rst_select", 32'(select),    32'h2);
    chk("post_rst_valid",  32'(out_valid), 32'h1);
    req = 4'b0000;
    step(2);
    chk("end_busy",   32'(busy),         32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
